contador_m_ud: RTL

CONTADOR_M_UD -- requirements
Module: contador_m_ud

---
 rtl/contador_m_ud_pkg.sv | 21 ++
 rtl/contador_m_ud_if.sv | 29 ++
 rtl/contador_m_ud_detector_limites.sv | 26 ++
 rtl/contador_m_ud.sv | 89 ++++++++
 4 files changed

// File: rtl/contador_m_ud_pkg.sv
// rtl/contador_m_ud_pkg.sv - shared encodings and modulus clamp helper for contador_m_ud
package contador_m_ud_pkg;

   localparam logic SOBE  = 1'b0;
   localparam logic DESCE = 1'b1;
   localparam logic WRAP  = 1'b0;
   localparam logic SAT   = 1'b1;

   // Zero becomes 1 and anything above 2^n is pulled down to 2^n.
   function automatic logic [16:0] clamp_mod(input logic [16:0] v, input int n);
      logic [16:0] top;
      top = 17'd1 << n;
      if (v == 17'd0)
         return 17'd1;
      else if (v > top)
         return top;
      else
         return v;
   endfunction

endpackage

// File: rtl/contador_m_ud_if.sv
// rtl/contador_m_ud_if.sv - signal bundle for driving and observing contador_m_ud
interface contador_m_ud_if #(parameter int N = 4);

   logic         zera_s;
   logic         conta;
   logic         desce;
   logic         modo_sat;
   logic         carrega;
   logic [N-1:0] D;
   logic         carrega_m;
   logic [N:0]   novo_m;
   logic [N-1:0] Q;
   logic [N:0]   M_atual;
   logic         fim;
   logic         meio;
   logic         inicio;
   logic         estouro;

   modport master (
      output zera_s, conta, desce, modo_sat, carrega, D, carrega_m, novo_m,
      input  Q, M_atual, fim, meio, inicio, estouro
   );

   modport slave (
      input  zera_s, conta, desce, modo_sat, carrega, D, carrega_m, novo_m,
      output Q, M_atual, fim, meio, inicio, estouro
   );

endinterface

// File: rtl/contador_m_ud_detector_limites.sv
// rtl/contador_m_ud_detector_limites.sv - combinational end/middle/start flags from count and modulus
module detector_limites #(
   parameter int N = 4
) (
   input  logic [N-1:0] q,
   input  logic [N:0]   m_atual,
   output logic         fim,
   output logic         meio,
   output logic         inicio
);

   logic [N:0] q_ext;
   logic [N:0] m_menos1;
   logic [N:0] meio_alvo;

   always_comb begin
      q_ext     = {1'b0, q};
      m_menos1  = m_atual - (N+1)'(1);
      meio_alvo = (m_atual >> 1) - (N+1)'(1);
      fim       = (q_ext == m_menos1);
      // Modulus 1 has no meaningful midpoint; the subtraction would wrap.
      meio      = (m_atual >= (N+1)'(2)) && (q_ext == meio_alvo);
      inicio    = (q == '0);
   end

endmodule

// File: rtl/contador_m_ud.sv
// rtl/contador_m_ud.sv - loadable up/down modulo-M counter with wrap/saturate and boundary pulse
module contador_m_ud
   import contador_m_ud_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 10
) (
   input  logic         clock,
   input  logic         zera_s,
   input  logic         conta,
   input  logic         desce,
   input  logic         modo_sat,
   input  logic         carrega,
   input  logic [N-1:0] D,
   input  logic         carrega_m,
   input  logic [N:0]   novo_m,
   output logic [N-1:0] Q,
   output logic [N:0]   M_atual,
   output logic         fim,
   output logic         meio,
   output logic         inicio,
   output logic         estouro
);

   localparam logic [N:0] M_INI = (N+1)'(M);

   logic [N-1:0] q_q, q_d;
   logic [N:0]   m_q, m_d;
   logic         estouro_q, estouro_d;
   logic [N:0]   m_menos1;
   logic [N:0]   q_ext;
   logic [16:0]  novo_clamp;

   always_comb begin
      q_d        = q_q;
      m_d        = m_q;
      estouro_d  = 1'b0;
      m_menos1   = m_q - (N+1)'(1);
      q_ext      = {1'b0, q_q};
      novo_clamp = clamp_mod(17'(novo_m), N);

      if (zera_s) begin
         q_d = '0;
         m_d = M_INI;
      end else if (carrega_m) begin
         m_d = novo_clamp[N:0];
         q_d = '0;
      end else if (carrega) begin
         q_d = ({1'b0, D} < m_q) ? D : m_menos1[N-1:0];
      end else if (conta) begin
         if (desce == SOBE) begin
            if (q_ext == m_menos1) begin
               estouro_d = 1'b1;
               if (modo_sat == WRAP)
                  q_d = '0;
            end else begin
               q_d = q_q + N'(1);
            end
         end else begin
            if (q_q == '0) begin
               estouro_d = 1'b1;
               if (modo_sat == WRAP)
                  q_d = m_menos1[N-1:0];
            end else begin
               q_d = q_q - N'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      q_q       <= q_d;
      m_q       <= m_d;
      estouro_q <= estouro_d;
   end

   assign Q       = q_q;
   assign M_atual = m_q;
   assign estouro = estouro_q;

   detector_limites #(.N(N)) u_detector (
      .q       (q_q),
      .m_atual (m_q),
      .fim     (fim),
      .meio    (meio),
      .inicio  (inicio)
   );

endmodule
